unidade_controle_mc: RTL and testbench
======================================

# unidade_controle_mc

Parametrised multicycle MIPS control unit that sequences fetch, decode and execute for the R-type (add/sub/and/break), lw, sw, beq, j and lui instructions. It adds a configurable memory wait-state count, branch/jump PC-source selection, a load-data register enable and a sticky halt. It sits between the instruction register (OPcode/funct), the ALU zero flag and every datapath mux and write enable.

## Interface
- MEM_WAIT, 1: memory latency in wait cycles after each read request; legal range 1..15.
- STATE_W, 6: width of the State debug output.
- clock  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; forces MEM_READ and clears the wait counter.
- OPcode  in  6  instruction opcode field from the IR.
- funct  in  6  R-type function field from the IR.
- Zero  in  1  ALU zero flag.
- EscreveMem  out  1  memory write enable.
- EscrevePC  out  1  PC write enable.
- RegDst  out  1  register destination: 0 = rt, 1 = rd.
- EscreveReg  out  1  register file write enable.
- MemparaReg  out  2  write-back source: 0 = ALUOut, 1 = MDR, 2 = {imm,16'h0}.
- IouD  out  1  memory address source: 0 = PC, 1 = ALUOut.
- EscreveIR  out  1  IR write enable.
- EscreveMDR  out  1  memory data register load enable.
- OrigAALU  out  1  ALU A source: 0 = PC, 1 = reg A.
- OrigBALU  out  2  ALU B source: 0 = reg B, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2.
- OpALU  out  3  ALU operation: 000 = pass A, 001 = add, 010 = sub, 111 = decode by funct.
- OrigPC  out  2  PC source: 0 = ALU result, 1 = ALUOut, 2 = jump target.
- Halt  out  1  high while in the BREAK state.
- State  out  STATE_W  current state encoding, zero-extended.

## Operation
- Moore outputs decoded from the state, except EscrevePC in BEQ, which equals Zero.
- Every output not listed for a state is 0.
- State encodings and asserted outputs:
  - MEM_READ = 0: IouD = 0, OrigAALU = 0, OrigBALU = 1, OpALU = 001, OrigPC = 0, EscrevePC = 1 (PC <= PC+4).
  - ESPERA = 1: all outputs 0. Held for MEM_WAIT cycles using a 4-bit counter.
  - IR_WRITE = 2: EscreveIR = 1, OrigAALU = 0, OrigBALU = 3, OpALU = 001 (precompute branch target).
  - DECODE = 3: all outputs 0. Dispatches on OPcode.
  - ADDR_CALC = 4: OrigAALU = 1, OrigBALU = 2, OpALU = 001.
  - LW_READ = 5: IouD = 1.
  - LW_WAIT = 6: IouD = 1. Held for MEM_WAIT cycles; EscreveMDR = 1 in the last cycle only.
  - LW_WB = 7: EscreveReg = 1, RegDst = 0, MemparaReg = 1.
  - SW_WRITE = 8: IouD = 1, EscreveMem = 1.
  - R_EXEC = 9: OrigAALU = 1, OrigBALU = 0, OpALU = 111.
  - R_WB = 10: EscreveReg = 1, RegDst = 1, MemparaReg = 0.
  - BEQ = 11: OrigAALU = 1, OrigBALU = 0, OpALU = 010, OrigPC = 1, EscrevePC = Zero.
  - JUMP = 12: OrigPC = 2, EscrevePC = 1.
  - LUI = 13: EscreveReg = 1, RegDst = 0, MemparaReg = 2.
  - BREAK = 14: Halt = 1, everything else 0.
- DECODE dispatch:
  - OPcode 0x00: funct 0x20/0x22/0x24 -> R_EXEC; funct 0x0d -> BREAK; any other funct -> BREAK.
  - OPcode 0x23 or 0x2b -> ADDR_CALC.
  - OPcode 0x04 -> BEQ.
  - OPcode 0x02 -> JUMP.
  - OPcode 0x0f -> LUI.
  - Any other OPcode -> BREAK.
- ADDR_CALC -> LW_READ if OPcode = 0x23, else SW_WRITE.
- LW_READ -> LW_WAIT -> LW_WB -> MEM_READ.
- SW_WRITE, R_WB, BEQ, JUMP and LUI -> MEM_READ.
- R_EXEC -> R_WB.
- BREAK is sticky; only reset leaves it.
- Unused encodings 15..63 -> MEM_READ on the next edge, with all outputs 0 while in them.

## Timing
- During and immediately after reset: State = 0 and outputs equal the MEM_READ values (EscrevePC = 1, OrigBALU = 1, OpALU = 001).
- Reset asserted mid-instruction returns to MEM_READ asynchronously with no further write enables.
- Wait counter loads MEM_WAIT-1 on entry to ESPERA or LW_WAIT and exits the state when it reaches 0. With MEM_WAIT = 1, each of these states lasts exactly 1 cycle.
- Cycles per instruction (F = 3 + MEM_WAIT fetch/decode):
  - beq, j, lui: F+1.
  - R-type and sw: F+2.
  - lw: F+3+MEM_WAIT.
- Zero is sampled combinationally only in BEQ; changes in Zero in any other state have no effect.

## Test plan
- Reset release, MEM_WAIT = 1, OPcode 0x00 / funct 0x20 -> State sequence 0,1,2,3,9,10,0; EscreveReg and RegDst high only in state 10.
- lw (0x23) with MEM_WAIT = 3 -> State sequence 0,1,1,1,2,3,4,5,6,6,6,7,0; EscreveMDR high only in the third state-6 cycle.
- beq (0x04) twice, Zero = 1 then Zero = 0 -> EscrevePC = 1 with OrigPC = 1 in state 11 the first time, EscrevePC = 0 the second time.
- OPcode 0x02 then 0x0f -> EscrevePC = 1 with OrigPC = 2 in state 12; EscreveReg = 1 with MemparaReg = 2 in state 13.
- OPcode 0x3f, and separately funct 0x0d -> BREAK (14) with Halt = 1 held for 20 cycles; reset -> State 0, Halt 0.
- Reset pulsed during LW_WAIT -> State 0 immediately; no EscreveMDR or EscreveReg pulse afterwards.

Source files
------------

// File: rtl/unidade_controle_mc.sv
// Multicycle MIPS control unit: fetch/decode/execute sequencing for R-type, lw, sw,
// beq, j and lui, with configurable memory wait states and a sticky BREAK halt.
module unidade_controle_mc #(
    parameter int MEM_WAIT = 1,
    parameter int STATE_W  = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [5:0]         OPcode,
    input  logic [5:0]         funct,
    input  logic               Zero,
    output logic               EscreveMem,
    output logic               EscrevePC,
    output logic               RegDst,
    output logic               EscreveReg,
    output logic [1:0]         MemparaReg,
    output logic               IouD,
    output logic               EscreveIR,
    output logic               EscreveMDR,
    output logic               OrigAALU,
    output logic [1:0]         OrigBALU,
    output logic [2:0]         OpALU,
    output logic [1:0]         OrigPC,
    output logic               Halt,
    output logic [STATE_W-1:0] State
);

    typedef enum logic [5:0] {
        MEM_READ  = 6'd0,
        ESPERA    = 6'd1,
        IR_WRITE  = 6'd2,
        DECODE    = 6'd3,
        ADDR_CALC = 6'd4,
        LW_READ   = 6'd5,
        LW_WAIT   = 6'd6,
        LW_WB     = 6'd7,
        SW_WRITE  = 6'd8,
        R_EXEC    = 6'd9,
        R_WB      = 6'd10,
        BEQ       = 6'd11,
        JUMP      = 6'd12,
        LUI       = 6'd13,
        BREAK     = 6'd14
    } state_t;

    typedef struct packed {
        logic       escreveMem;
        logic       escrevePc;
        logic       regDst;
        logic       escreveReg;
        logic [1:0] memparaReg;
        logic       iouD;
        logic       escreveIr;
        logic       escreveMdr;
        logic       origAAlu;
        logic [1:0] origBAlu;
        logic [2:0] opAlu;
        logic [1:0] origPc;
        logic       halt;
        logic       beqSel;
    } ctrl_t;

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

    state_t     stateReg, stateNext;
    logic [3:0] waitReg, waitNext;
    ctrl_t      ctrlReg;

    // Output decode for a given state; waitDone marks the final cycle of a wait state.
    function automatic ctrl_t decodeCtrl(input state_t s, input logic waitDone);
        ctrl_t c;
        c = '0;
        case (s)
            MEM_READ: begin
                c.origBAlu  = 2'd1;
                c.opAlu     = 3'b001;
                c.escrevePc = 1'b1;
            end
            IR_WRITE: begin
                c.escreveIr = 1'b1;
                c.origBAlu  = 2'd3;
                c.opAlu     = 3'b001;
            end
            ADDR_CALC: begin
                c.origAAlu = 1'b1;
                c.origBAlu = 2'd2;
                c.opAlu    = 3'b001;
            end
            LW_READ: c.iouD = 1'b1;
            LW_WAIT: begin
                c.iouD       = 1'b1;
                c.escreveMdr = waitDone;
            end
            LW_WB: begin
                c.escreveReg = 1'b1;
                c.memparaReg = 2'd1;
            end
            SW_WRITE: begin
                c.iouD       = 1'b1;
                c.escreveMem = 1'b1;
            end
            R_EXEC: begin
                c.origAAlu = 1'b1;
                c.opAlu    = 3'b111;
            end
            R_WB: begin
                c.escreveReg = 1'b1;
                c.regDst     = 1'b1;
            end
            BEQ: begin
                c.origAAlu = 1'b1;
                c.opAlu    = 3'b010;
                c.origPc   = 2'd1;
                c.beqSel   = 1'b1;
            end
            JUMP: begin
                c.origPc    = 2'd2;
                c.escrevePc = 1'b1;
            end
            LUI: begin
                c.escreveReg = 1'b1;
                c.memparaReg = 2'd2;
            end
            BREAK:   c.halt = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        stateNext = MEM_READ;
        waitNext  = waitReg;
        case (stateReg)
            MEM_READ: begin
                stateNext = ESPERA;
                waitNext  = WAIT_LOAD;
            end
            ESPERA: begin
                if (waitReg == 4'd0) begin
                    stateNext = IR_WRITE;
                end else begin
                    stateNext = ESPERA;
                    waitNext  = waitReg - 4'd1;
                end
            end
            IR_WRITE: stateNext = DECODE;
            DECODE: begin
                case (OPcode)
                    6'h00: begin
                        if (funct == 6'h20 || funct == 6'h22 || funct == 6'h24)
                            stateNext = R_EXEC;
                        else
                            stateNext = BREAK;
                    end
                    6'h23, 6'h2b: stateNext = ADDR_CALC;
                    6'h04:        stateNext = BEQ;
                    6'h02:        stateNext = JUMP;
                    6'h0f:        stateNext = LUI;
                    default:      stateNext = BREAK;
                endcase
            end
            ADDR_CALC: stateNext = (OPcode == 6'h23) ? LW_READ : SW_WRITE;
            LW_READ: begin
                stateNext = LW_WAIT;
                waitNext  = WAIT_LOAD;
            end
            LW_WAIT: begin
                if (waitReg == 4'd0) begin
                    stateNext = LW_WB;
                end else begin
                    stateNext = LW_WAIT;
                    waitNext  = waitReg - 4'd1;
                end
            end
            R_EXEC:  stateNext = R_WB;
            BREAK:   stateNext = BREAK;
            default: stateNext = MEM_READ;
        endcase
    end

    // Outputs are registered from the next-state decode so they track the state exactly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stateReg <= MEM_READ;
            waitReg  <= 4'd0;
            ctrlReg  <= decodeCtrl(MEM_READ, 1'b0);
        end else begin
            stateReg <= stateNext;
            waitReg  <= waitNext;
            ctrlReg  <= decodeCtrl(stateNext, waitNext == 4'd0);
        end
    end

    assign EscreveMem = ctrlReg.escreveMem;
    assign EscrevePC  = ctrlReg.escrevePc | (ctrlReg.beqSel & Zero);
    assign RegDst     = ctrlReg.regDst;
    assign EscreveReg = ctrlReg.escreveReg;
    assign MemparaReg = ctrlReg.memparaReg;
    assign IouD       = ctrlReg.iouD;
    assign EscreveIR  = ctrlReg.escreveIr;
    assign EscreveMDR = ctrlReg.escreveMdr;
    assign OrigAALU   = ctrlReg.origAAlu;
    assign OrigBALU   = ctrlReg.origBAlu;
    assign OpALU      = ctrlReg.opAlu;
    assign OrigPC     = ctrlReg.origPc;
    assign Halt       = ctrlReg.halt;
    assign State      = STATE_W'(stateReg);

endmodule

// File: tb/tb_unidade_controle_mc.sv
// Directed bench for unidade_controle_mc: one instance with MEM_WAIT=1 for the
// R-type sequence, one with MEM_WAIT=3 for all other instruction flows.
module tb_unidade_controle_mc;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst1, rst3;
    logic [5:0] OPcode, funct;
    logic       Zero;

    logic       EscreveMem1, EscrevePC1, RegDst1, EscreveReg1, IouD1, EscreveIR1, EscreveMDR1, OrigAALU1, Halt1;
    logic [1:0] MemparaReg1, OrigBALU1, OrigPC1;
    logic [2:0] OpALU1;
    logic [5:0] State1;

    logic       EscreveMem3, EscrevePC3, RegDst3, EscreveReg3, IouD3, EscreveIR3, EscreveMDR3, OrigAALU3, Halt3;
    logic [1:0] MemparaReg3, OrigBALU3, OrigPC3;
    logic [2:0] OpALU3;
    logic [5:0] State3;

    unidade_controle_mc #(.MEM_WAIT(1), .STATE_W(6)) dut1 (
        .clock(clock), .reset(rst1), .OPcode(OPcode), .funct(funct), .Zero(Zero),
        .EscreveMem(EscreveMem1), .EscrevePC(EscrevePC1), .RegDst(RegDst1),
        .EscreveReg(EscreveReg1), .MemparaReg(MemparaReg1), .IouD(IouD1),
        .EscreveIR(EscreveIR1), .EscreveMDR(EscreveMDR1), .OrigAALU(OrigAALU1),
        .OrigBALU(OrigBALU1), .OpALU(OpALU1), .OrigPC(OrigPC1), .Halt(Halt1),
        .State(State1)
    );

    unidade_controle_mc #(.MEM_WAIT(3), .STATE_W(6)) dut3 (
        .clock(clock), .reset(rst3), .OPcode(OPcode), .funct(funct), .Zero(Zero),
        .EscreveMem(EscreveMem3), .EscrevePC(EscrevePC3), .RegDst(RegDst3),
        .EscreveReg(EscreveReg3), .MemparaReg(MemparaReg3), .IouD(IouD3),
        .EscreveIR(EscreveIR3), .EscreveMDR(EscreveMDR3), .OrigAALU(OrigAALU3),
        .OrigBALU(OrigBALU3), .OpALU(OpALU3), .OrigPC(OrigPC3), .Halt(Halt3),
        .State(State3)
    );

    // Full output vector of dut1, packed as
    // {EscreveMem,EscrevePC,RegDst,EscreveReg,MemparaReg,IouD,EscreveIR,EscreveMDR,OrigAALU,OrigBALU,OpALU,OrigPC,Halt}
    logic [17:0] ctrl1;
    assign ctrl1 = {EscreveMem1, EscrevePC1, RegDst1, EscreveReg1, MemparaReg1, IouD1,
                    EscreveIR1, EscreveMDR1, OrigAALU1, OrigBALU1, OpALU1, OrigPC1, Halt1};

    int          rSeq[7]  = '{0, 1, 2, 3, 9, 10, 0};
    logic [17:0] rCtrl[7] = '{18'b0_1_0_0_00_0_0_0_0_01_001_00_0,
                              18'b0_0_0_0_00_0_0_0_0_00_000_00_0,
                              18'b0_0_0_0_00_0_1_0_0_11_001_00_0,
                              18'b0_0_0_0_00_0_0_0_0_00_000_00_0,
                              18'b0_0_0_0_00_0_0_0_1_00_111_00_0,
                              18'b0_0_1_1_00_0_0_0_0_00_000_00_0,
                              18'b0_1_0_0_00_0_0_0_0_01_001_00_0};
    int          lwSeq[12] = '{0, 1, 1, 1, 2, 3, 4, 5, 6, 6, 6, 7};

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Fetch/decode with MEM_WAIT=3: states 0,1,1,1,2,3, one per cycle.
    task automatic fetch3(input string tag);
        for (int i = 0; i < 6; i++) begin
            check({tag, "_fetch_state"}, State3, (i == 0) ? 0 : (i < 4) ? 1 : i - 2);
            check({tag, "_fetch_noreg"}, EscreveReg3, 0);
            @(negedge clock);
        end
    endtask

    task automatic resetHalted(input string tag);
        #2 rst3 = 1'b1;
        #1;
        check({tag, "_rst_state"}, State3, 0);
        check({tag, "_rst_halt"}, Halt3, 0);
        check({tag, "_rst_pc"}, EscrevePC3, 1);
        @(negedge clock);
        rst3 = 1'b0;
    endtask

    initial begin
        rst1 = 1'b1; rst3 = 1'b1;
        OPcode = 6'h00; funct = 6'h20; Zero = 1'b0;
        repeat (2) @(negedge clock);

        check("reset_state", State3, 0);
        check("reset_pc", EscrevePC3, 1);
        check("reset_origb", OrigBALU3, 1);
        check("reset_opalu", OpALU3, 3'b001);
        check("reset_halt", Halt3, 0);
        check("reset_ir", EscreveIR3, 0);

        // R-type add on the MEM_WAIT=1 instance
        rst1 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check("rtype_state", State1, rSeq[i]);
            check("rtype_ctrl", ctrl1, rCtrl[i]);
            @(negedge clock);
        end
        rst1 = 1'b1;
        $display("txn rtype add sequence at %0t", $time);

        // lw on the MEM_WAIT=3 instance
        OPcode = 6'h23;
        rst3 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("lw_state", State3, lwSeq[i]);
            check("lw_mdr", EscreveMDR3, (i == 10) ? 1 : 0);
            check("lw_reg", EscreveReg3, (i == 11) ? 1 : 0);
            if (i == 11) check("lw_memreg", MemparaReg3, 1);
            if (i >= 7 && i <= 10) check("lw_iord", IouD3, 1);
            @(negedge clock);
        end
        $display("txn lw at %0t", $time);

        // beq taken
        OPcode = 6'h04; Zero = 1'b1;
        fetch3("beq1");
        check("beq1_state", State3, 11);
        check("beq1_pc", EscrevePC3, 1);
        check("beq1_origpc", OrigPC3, 1);
        check("beq1_opalu", OpALU3, 3'b010);
        check("beq1_origa", OrigAALU3, 1);
        @(negedge clock);
        $display("txn beq zero=1 at %0t", $time);

        // beq not taken, then Zero flipped live within BEQ
        Zero = 1'b0;
        fetch3("beq0");
        check("beq0_state", State3, 11);
        check("beq0_pc", EscrevePC3, 0);
        Zero = 1'b1; #1;
        check("beq0_pc_live", EscrevePC3, 1);
        Zero = 1'b0; #1;
        check("beq0_pc_back", EscrevePC3, 0);
        @(negedge clock);
        $display("txn beq zero=0 at %0t", $time);

        OPcode = 6'h02;
        fetch3("j");
        check("j_state", State3, 12);
        check("j_pc", EscrevePC3, 1);
        check("j_origpc", OrigPC3, 2);
        @(negedge clock);
        $display("txn j at %0t", $time);

        OPcode = 6'h0f; Zero = 1'b1;
        fetch3("lui");
        check("lui_state", State3, 13);
        check("lui_reg", EscreveReg3, 1);
        check("lui_memreg", MemparaReg3, 2);
        check("lui_regdst", RegDst3, 0);
        check("lui_pc_zero_ignored", EscrevePC3, 0);
        @(negedge clock);
        Zero = 1'b0;
        $display("txn lui at %0t", $time);

        OPcode = 6'h2b;
        fetch3("sw");
        check("sw_addr_state", State3, 4);
        check("sw_origb", OrigBALU3, 2);
        @(negedge clock);
        check("sw_state", State3, 8);
        check("sw_mem", EscreveMem3, 1);
        check("sw_iord", IouD3, 1);
        @(negedge clock);
        $display("txn sw at %0t", $time);

        OPcode = 6'h3f;
        fetch3("brk_op");
        for (int i = 0; i < 20; i++) begin
            check("brk_op_state", State3, 14);
            check("brk_op_halt", Halt3, 1);
            @(negedge clock);
        end
        resetHalted("brk_op");
        $display("txn break opcode 0x3f at %0t", $time);

        OPcode = 6'h00; funct = 6'h0d;
        fetch3("brk_fn");
        for (int i = 0; i < 4; i++) begin
            check("brk_fn_state", State3, 14);
            check("brk_fn_halt", Halt3, 1);
            @(negedge clock);
        end
        resetHalted("brk_fn");
        funct = 6'h20;
        $display("txn break funct 0x0d at %0t", $time);

        // Reset while waiting on load data
        OPcode = 6'h23;
        fetch3("lwrst");
        check("lwrst_addr", State3, 4);
        @(negedge clock);
        check("lwrst_read", State3, 5);
        @(negedge clock);
        check("lwrst_wait", State3, 6);
        check("lwrst_wait_mdr", EscreveMDR3, 0);
        #2 rst3 = 1'b1;
        #1;
        check("lwrst_async_state", State3, 0);
        check("lwrst_async_mdr", EscreveMDR3, 0);
        @(negedge clock);
        rst3 = 1'b0;
        OPcode = 6'h3f;
        for (int i = 0; i < 6; i++) begin
            check("lwrst_after_state", State3, (i == 0) ? 0 : (i < 4) ? 1 : i - 2);
            check("lwrst_after_mdr", EscreveMDR3, 0);
            check("lwrst_after_reg", EscreveReg3, 0);
            @(negedge clock);
        end
        $display("txn lw reset during wait at %0t", $time);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
